// File: rtl/decoder24_scan_pkg.sv
// Shared definitions for the registered 2-to-4 decoder with scan sequencer:
// state encoding, output width and the default scan prescale.
package decoder24_scan_pkg;

  localparam int ONEHOT_W    = 4;
  localparam int IDX_W       = 2;
  localparam int DEFAULT_DIV = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

endpackage

// File: rtl/decoder24_scan_prescaler_tick.sv
// Reusable CW-bit prescaler: counts 0..DIV-1 while enabled and flags the
// terminal count combinationally so the owner can register its own pulse.
module prescaler_tick #(
  parameter int DIV = 4,
  parameter int CW  = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [CW-1:0] TC_VALUE = CW'(DIV - 1);

  logic [CW-1:0] r_count;

  assign o_tc = (r_count == TC_VALUE);

  // Clear wins over counting so a fresh scan always starts a full period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= o_tc ? '0 : r_count + CW'(1);
    end
  end

endmodule

// File: rtl/decoder24_scan.sv
// Registered 2-to-4 one-hot select driver with direct (loaded index) and
// scan (prescaled 0..3 walk) modes; every output comes straight from a flop.
module decoder24_scan
  import decoder24_scan_pkg::*;
#(
  parameter int DIV        = DEFAULT_DIV,
  parameter int CW         = 16,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                mode,
  input  logic                load,
  input  logic [IDX_W-1:0]    sel,
  output logic [ONEHOT_W-1:0] y,
  output logic [IDX_W-1:0]    idx,
  output logic                tick,
  output logic                busy
);

  localparam logic [ONEHOT_W-1:0] Y_INACTIVE = {ONEHOT_W{ACTIVE_LOW}};

  state_t              r_state;
  state_t              w_stateNext;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    w_idxNext;
  logic [ONEHOT_W-1:0] r_y;
  logic [ONEHOT_W-1:0] w_yNext;
  logic [ONEHOT_W-1:0] w_dec;
  logic                r_tick;
  logic                r_busy;
  logic                w_scanEnter;
  logic                w_scanRun;
  logic                w_capture;
  logic                w_tc;
  logic                w_step;

  prescaler_tick #(
    .DIV (DIV),
    .CW  (CW)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_scanEnter),
    .i_en  (w_scanRun),
    .o_tc  (w_tc)
  );

  // Mode changes take effect on the edge they are seen, so a load or step
  // coinciding with a switch is dropped by requiring the state to persist.
  always_comb begin
    w_stateNext = r_state;
    w_scanEnter = 1'b0;
    w_scanRun   = 1'b0;
    w_capture   = 1'b0;
    if (!en) begin
      w_stateNext = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   w_stateNext = mode ? ST_SCAN : ST_DIRECT;
        ST_DIRECT: if (mode) w_stateNext = ST_SCAN;
        ST_SCAN:   if (!mode) w_stateNext = ST_DIRECT;
        default:   w_stateNext = ST_IDLE;
      endcase
    end
    w_scanEnter = (w_stateNext == ST_SCAN) && (r_state != ST_SCAN);
    w_scanRun   = (w_stateNext == ST_SCAN) && (r_state == ST_SCAN);
    w_capture   = (w_stateNext == ST_DIRECT) && (r_state == ST_DIRECT) && load;
  end

  assign w_step    = w_scanRun && w_tc;
  assign w_idxNext = w_capture ? sel : (w_step ? r_idx + IDX_W'(1) : r_idx);
  assign w_dec     = ONEHOT_W'(1) << r_idx;
  assign w_yNext   = (w_stateNext == ST_IDLE) ? Y_INACTIVE
                   : (ACTIVE_LOW ? ~w_dec : w_dec);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_y     <= Y_INACTIVE;
      r_tick  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_idx   <= w_idxNext;
      r_y     <= w_yNext;
      r_tick  <= w_step;
      r_busy  <= (w_stateNext == ST_SCAN);
    end
  end

  assign y    = r_y;
  assign idx  = r_idx;
  assign tick = r_tick;
  assign busy = r_busy;

endmodule

// File: tb/tb_decoder24_scan.sv
// Self-checking bench: two decoder instances (DIV=4 active-high, DIV=1
// active-low) against a behavioural model, plus directed literal checks.
module tb_decoder24_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic       load = 1'b0;
  logic [1:0] sel = 2'd0;
  logic [3:0] yA, yB;
  logic [1:0] idxA, idxB;
  logic       tickA, tickB, busyA, busyB;

  int  checkCount = 0;
  int  passCount = 0;
  bit  chk = 1'b0;

  decoder24_scan #(.DIV(4), .CW(16), .ACTIVE_LOW(1'b0)) dutA (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .sel(sel),
    .y(yA), .idx(idxA), .tick(tickA), .busy(busyA)
  );

  decoder24_scan #(.DIV(1), .CW(16), .ACTIVE_LOW(1'b1)) dutB (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .sel(sel),
    .y(yB), .idx(idxB), .tick(tickB), .busy(busyB)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] decodeRef(int i, bit al);
    logic [3:0] v;
    v = 4'(2 ** i);
    return al ? ~v : v;
  endfunction

  // Behavioural model: "on" means enabled, "scan" means scanning;
  // cyc counts cycles since the scan (re)started, stepping each DIV.
  int         mDiv[2] = '{4, 1};
  bit         mAl[2]  = '{1'b0, 1'b1};
  bit         mOn[2];
  bit         mScan[2];
  int         mIdx[2];
  int         mCyc[2];
  bit         mTick[2];
  bit         mBusy[2];
  logic [3:0] mY[2]   = '{4'h0, 4'hF};

  always @(posedge clk or posedge rst) begin
    logic [3:0] nextY;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mOn[k] = 0; mScan[k] = 0; mIdx[k] = 0; mCyc[k] = 0;
        mTick[k] = 0; mBusy[k] = 0; mY[k] = mAl[k] ? 4'hF : 4'h0;
      end else begin
        nextY = en ? decodeRef(mIdx[k], mAl[k]) : (mAl[k] ? 4'hF : 4'h0);
        mTick[k] = 0;
        if (!en) begin
          mOn[k] = 0; mScan[k] = 0;
        end else begin
          if (mOn[k] && mScan[k] && mode) begin
            mCyc[k] = mCyc[k] + 1;
            if (mCyc[k] % mDiv[k] == 0) begin
              mIdx[k] = (mIdx[k] + 1) % 4;
              mTick[k] = 1;
            end
          end else if (mOn[k] && !mScan[k] && !mode) begin
            if (load) mIdx[k] = int'(sel);
          end else if (mode) begin
            mCyc[k] = 0;
          end
          mOn[k] = 1; mScan[k] = mode;
        end
        mBusy[k] = mScan[k];
        mY[k] = nextY;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk) begin
      checkOutput("model_yA", yA, mY[0]);
      checkOutput("model_idxA", {2'b00, idxA}, 4'(mIdx[0]));
      checkOutput("model_tickA", {3'b000, tickA}, {3'b000, mTick[0]});
      checkOutput("model_busyA", {3'b000, busyA}, {3'b000, mBusy[0]});
      checkOutput("model_yB", yB, mY[1]);
      checkOutput("model_idxB", {2'b00, idxB}, 4'(mIdx[1]));
      checkOutput("model_tickB", {3'b000, tickB}, {3'b000, mTick[1]});
      checkOutput("model_busyB", {3'b000, busyB}, {3'b000, mBusy[1]});
    end
  end

  task automatic applyStimulus(input bit e, input bit m, input bit l, input logic [1:0] s);
    en = e; mode = m; load = l; sel = s;
    @(negedge clk);
  endtask

  initial begin
    int prev;
    int s;
    bit rmode;
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk = 1'b1;
    checkOutput("rst_yA", yA, 4'h0);
    checkOutput("rst_yB", yB, 4'hF);
    checkOutput("rst_idxA", {2'b00, idxA}, 4'd0);
    checkOutput("rst_busyA", {3'b000, busyA}, 4'd0);
    checkOutput("rst_tickA", {3'b000, tickA}, 4'd0);

    // Direct mode: loads of 2,3,0,1,2 with latency 1 to idx, 2 to y
    applyStimulus(1, 0, 0, 2'd0);
    checkOutput("direct_entry_yA", yA, 4'b0001);
    prev = 0;
    for (int i = 0; i < 5; i++) begin
      s = (i + 2) % 4;
      applyStimulus(1, 0, 1, 2'(s));
      checkOutput("load_idxA", {2'b00, idxA}, 4'(s));
      checkOutput("load_yA_old", yA, decodeRef(prev, 0));
      applyStimulus(1, 0, 0, 2'(s));
      checkOutput("load_yA", yA, decodeRef(s, 0));
      checkOutput("load_yB", yB, ~decodeRef(s, 0));
      prev = s;
    end

    // Scan from idx 2, DIV=4
    applyStimulus(1, 1, 0, 2'd0);
    checkOutput("scan_busyA", {3'b000, busyA}, 4'd1);
    checkOutput("scan_entry_yA", yA, 4'b0100);
    for (int st = 1; st <= 4; st++) begin
      repeat (3) applyStimulus(1, 1, 0, 2'd0);
      checkOutput("scan_notickA", {3'b000, tickA}, 4'd0);
      checkOutput("scan_yA", yA, decodeRef((2 + st - 1) % 4, 0));
      checkOutput("scan_tickB", {3'b000, tickB}, 4'd1);
      checkOutput("scan_oneB", 4'($countones(~yB)), 4'd1);
      applyStimulus(1, 1, 0, 2'd0);
      checkOutput("scan_step_idxA", {2'b00, idxA}, 4'((2 + st) % 4));
      checkOutput("scan_tickA", {3'b000, tickA}, 4'd1);
      checkOutput("scan_busyA_run", {3'b000, busyA}, 4'd1);
    end

    // Disable for 3 cycles, then resume scanning from held idx
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 2'd0);
      checkOutput("dis_yA", yA, 4'h0);
      checkOutput("dis_yB", yB, 4'hF);
      checkOutput("dis_tickA", {3'b000, tickA}, 4'd0);
      checkOutput("dis_tickB", {3'b000, tickB}, 4'd0);
      checkOutput("dis_idxA", {2'b00, idxA}, 4'd2);
    end
    applyStimulus(1, 1, 0, 2'd0);
    checkOutput("resume_yA", yA, 4'b0100);
    repeat (3) applyStimulus(1, 1, 0, 2'd0);
    checkOutput("resume_notickA", {3'b000, tickA}, 4'd0);
    applyStimulus(1, 1, 0, 2'd0);
    checkOutput("resume_tickA", {3'b000, tickA}, 4'd1);
    checkOutput("resume_idxA", {2'b00, idxA}, 4'd3);

    // Mode switch with load on the terminal cycle: no step, load dropped
    repeat (3) applyStimulus(1, 1, 0, 2'd0);
    applyStimulus(1, 0, 1, 2'd1);
    checkOutput("switch_idxA", {2'b00, idxA}, 4'd3);
    checkOutput("switch_tickA", {3'b000, tickA}, 4'd0);
    checkOutput("switch_busyA", {3'b000, busyA}, 4'd0);
    applyStimulus(1, 0, 1, 2'd1);
    applyStimulus(1, 0, 0, 2'd0);
    checkOutput("switch_load_yA", yA, 4'b0010);

    // Asynchronous reset mid-scan, between clock edges
    repeat (5) applyStimulus(1, 1, 0, 2'd0);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_yA", yA, 4'h0);
    checkOutput("arst_yB", yB, 4'hF);
    checkOutput("arst_idxA", {2'b00, idxA}, 4'd0);
    checkOutput("arst_busyA", {3'b000, busyA}, 4'd0);
    checkOutput("arst_busyB", {3'b000, busyB}, 4'd0);
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic
    rmode = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 6) rmode = ~rmode;
      applyStimulus($urandom_range(0, 99) < 90, rmode, 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)));
      if ($urandom_range(0, 199) == 0) begin
        #2 rst = 1'b1;
        #1 rst = 1'b0;
      end
    end

    chk = 1'b0;
    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/decoder24_scan.md
Name: decoder24_scan

Overview:
- Registered 2-to-4 one-hot decoder: the inverse of the lab's 4-to-2 encoder, with a built-in scan sequencer.
- Drives 4-line selects such as 7-segment digit anodes or LED banks.
- Operating modes:
  - Direct: decodes a loaded 2-bit index.
  - Scan: walks the index 0→1→2→3→0 at a prescaled rate.
  - Disabled: blanks all outputs.
- Sits between a control FSM or switch inputs and the board's select lines.

Parameters:
- DIV, 4, prescaler period in clk cycles per scan step (legal 1..65535).
- CW, 16, prescaler counter width (must hold DIV-1).
- ACTIVE_LOW, 0, 1 inverts y for active-low drivers (inactive level = 1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- en  input  1  output enable; 0 blanks y and freezes the sequencer.
- mode  input  1  0 = direct, 1 = scan.
- load  input  1  direct-mode strobe; captures sel.
- sel  input  2  index to decode.
- y  output  4  registered one-hot select (polarity per ACTIVE_LOW).
- idx  output  2  current index driving y.
- tick  output  1  one-cycle pulse on each scan step.
- busy  output  1  1 while in SCAN state.

Behaviour:
- Reset (async, rst=1): state=IDLE, idx=0, prescaler=0, tick=0, busy=0, y=all inactive (4'b0000, or 4'b1111 if ACTIVE_LOW).
- States:
  - IDLE: en=0, or just out of reset.
  - DIRECT.
  - SCAN.
- Transitions, evaluated each rising edge:
  - en=0 from any state → IDLE. idx and prescaler hold their values; y goes inactive the next cycle; tick=0.
  - IDLE with en=1 → DIRECT if mode=0, else SCAN.
  - DIRECT with mode=1 → SCAN.
  - SCAN with mode=0 → DIRECT.
- DIRECT:
  - load=1 captures idx<=sel.
  - y reflects the new idx on the edge after capture (latency 1 from load to idx, latency 2 from load to y).
  - load=0 holds idx.
- Decode: y<=1<<idx each cycle in DIRECT or SCAN (inverted when ACTIVE_LOW). Exactly one line is active whenever en=1 and state≠IDLE.
- SCAN:
  - Entering SCAN clears the prescaler to 0. idx continues from its current value, with no jump.
  - Prescaler increments each cycle. When it reaches DIV-1: prescaler<=0, idx<=idx+1 mod 4 (3 wraps to 0), tick=1 for that one cycle.
  - DIV=1 steps idx every cycle with tick held high.
  - load is ignored.
- Simultaneous events, highest priority first: rst > en=0 > mode change > load/prescaler step.
  - A load arriving on the same edge as a DIRECT→SCAN switch is dropped.
  - A mode switch on the prescaler terminal cycle produces no step.
- busy=1 exactly when state=SCAN, registered.
- rst asserted mid-scan forces the reset values immediately, without waiting for clk.
- Output glitch rule: y, idx, tick and busy are all flops; no combinational path from inputs to outputs.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=2'd0, ST_DIRECT=2'd1, ST_SCAN=2'd2;
  - default DIV;
  - the one-hot width constant 4.
- One natural sub-module: prescaler_tick (CW-bit counter with clear, enable and terminal-count pulse). It is reusable by the display and debounce blocks.
- The decoder function itself stays inline.

Test Plan:
- rst=1 mid-operation, async between edges → y=4'b0000, idx=0, busy=0 immediately. With ACTIVE_LOW=1 → y=4'b1111.
- en=1, mode=0, load pulse sel=2'b10 → idx=2 one edge later, y=4'b0100 one edge after that. Repeat for sel=0..3 → y=0001/0010/0100/1000.
- mode=1, DIV=4, start idx=2 → tick every 4 cycles. idx sequence 2,3,0,1,2 and y sequence 0100,1000,0001,0010,0100. busy=1 throughout.
- In SCAN, drop en to 0 for 3 cycles, then raise it again → y=0000 and tick=0 while disabled. On return, idx resumes from its held value. First step comes DIV cycles after re-entry.
- Switch mode 1→0 on the prescaler terminal cycle, together with load sel=1 → no step, state=DIRECT, load ignored that edge. Next load sel=1 → y=0010.
- DIV=1 scan → idx increments every cycle, tick stays 1, exactly one y bit active every cycle.
